uart_tx_gen: RTL and testbench

Parametrised, next-generation UART transmitter. Adds a programmable baud divider, a valid/ready input handshake with a one-entry holding buffer for gap-free back-to-back frames, and four parity modes. It also adds break generation and illegal-length error reporting. It sits between the bus-side data source and the serial tx pin, alongside the existing UART receive path.

---
 rtl/uart_tx_gen_pkg.sv | 44 ++++
 rtl/uart_tx_gen_if.sv | 13 +
 rtl/uart_tx_gen_baud_gen.sv | 35 +++
 rtl/uart_tx_gen.sv | 196 +++++++++++++++++++
 tb/tb_uart_tx_gen.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_gen_pkg.sv
// Shared UART types: transmitter FSM states, parity modes, minimum frame length.
// The parity helper is also used by the receive path, so it takes a fixed-width
// argument and a runtime length instead of depending on a module parameter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        BRK_REC
    } tx_state_e;

    typedef enum logic [1:0] {
        PAR_EVEN,
        PAR_ODD,
        PAR_MARK,
        PAR_SPACE
    } parity_e;

    localparam int unsigned MIN_LEN = 5;

    // Parity over data[len-1:0] only; bits at or above len are ignored.
    function automatic logic parity_bit(input logic [15:0] data,
                                        input logic [7:0]  len,
                                        input parity_e     ptype);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i < int'(len)) begin
                p = p ^ data[i];
            end
        end
        case (ptype)
            PAR_EVEN:  return p;
            PAR_ODD:   return ~p;
            PAR_MARK:  return 1'b1;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_gen_if.sv
// Valid/ready word interface between the bus-side source and the UART transmitter.
// master = data source (drives s_valid/s_data), slave = transmitter (drives s_ready).
// Transfer happens on a rising edge with s_valid && s_ready both high.
interface uart_tx_gen_if #(
    parameter int DATA_W = 8
) ();
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/uart_tx_gen_baud_gen.sv
// Baud timer: down-counter that marks the last clock of each serial bit.
// Latency: o_bit_end is combinational from the counter; bit length = max(i_div,1) clocks.
// Backpressure: none; i_load restarts the bit and latches the divisor for auto-reload.
// Ports: clk/rst_n, i_load + i_div (restart with new divisor), i_en (count), o_bit_end.
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_en,
    output logic             o_bit_end
);
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_reload;
    logic [DIV_W-1:0] w_div_m1;

    // Divisor 0 and 1 both give a one-clock bit.
    assign w_div_m1 = (i_div == '0) ? '0 : i_div - DIV_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_reload <= '0;
        end else if (i_load) begin
            r_cnt    <= w_div_m1;
            r_reload <= w_div_m1;
        end else if (i_en) begin
            r_cnt <= (r_cnt == '0) ? r_reload : r_cnt - DIV_W'(1);
        end
    end

    assign o_bit_end = i_en && (r_cnt == '0);
endmodule

// File: rtl/uart_tx_gen.sv
// UART transmitter with one-entry holding buffer, programmable baud, parity, stop bits, break.
// Latency: word accepted on edge N launches START on edge N+1 when idle; back-to-back frames are gap-free.
// Backpressure: s_ready = holding buffer empty; freed the cycle a frame launches or is rejected.
// Ports: tx_clk/rst (async active-low); divisor/length/parity_en/parity_type/stop2 are snapshotted
// with each accepted word; brk requests a break while idle; s_if carries the word handshake;
// tx serial out (idle high), tx_busy, tx_done (last clock of final stop), tx_err (bad length).
module uart_tx_gen
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16,
    parameter int LEN_W  = 4
) (
    input  logic             tx_clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] divisor,
    input  logic [LEN_W-1:0] length,
    input  logic             parity_en,
    input  logic [1:0]       parity_type,
    input  logic             stop2,
    input  logic             brk,
    uart_tx_gen_if.slave     s_if,
    output logic             tx,
    output logic             tx_busy,
    output logic             tx_done,
    output logic             tx_err
);
    typedef struct packed {
        logic [DIV_W-1:0] div;
        logic [LEN_W-1:0] len;
        logic             pen;
        parity_e          ptype;
        logic             stop2;
    } cfg_t;

    tx_state_e         r_state, w_state_nxt;
    logic              r_hold_full;
    logic [DATA_W-1:0] r_hold_data;
    cfg_t              r_hold_cfg;
    logic [DATA_W-1:0] r_shift;
    logic [LEN_W-1:0]  r_bit_cnt;
    logic [LEN_W-1:0]  r_len;
    logic              r_pen;
    logic              r_stop2;
    logic              r_par;
    logic              r_brk;
    logic              r_err;

    logic              w_accept;
    logic              w_try;
    logic              w_launch;
    logic              w_drop;
    logic              w_len_ok;
    logic              w_load;
    logic [DIV_W-1:0]  w_load_div;
    logic              w_bit_end;
    logic              w_final_stop;

    assign w_accept = s_if.s_valid && !r_hold_full;
    assign s_if.s_ready = !r_hold_full;

    assign w_len_ok = (32'(r_hold_cfg.len) >= MIN_LEN) && (32'(r_hold_cfg.len) <= DATA_W);

    assign w_final_stop = (r_state == STOP2) || (r_state == STOP1 && !r_stop2);

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk       (tx_clk),
        .rst_n     (rst),
        .i_load    (w_load),
        .i_div     (w_load_div),
        .i_en      (r_state != IDLE),
        .o_bit_end (w_bit_end)
    );

    always_ff @(posedge tx_clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // w_try marks every point where a buffered word may start: idle with no break,
    // end of break recovery, or the last clock of the final stop bit.
    always_comb begin
        w_state_nxt = r_state;
        w_try       = 1'b0;
        w_launch    = 1'b0;
        w_drop      = 1'b0;
        w_load      = 1'b0;
        w_load_div  = r_hold_cfg.div;
        case (r_state)
            IDLE: begin
                if (r_brk && !brk) begin
                    w_state_nxt = BRK_REC;
                    w_load      = 1'b1;
                    w_load_div  = divisor;
                end else if (!brk && !r_brk && r_hold_full) begin
                    w_try = 1'b1;
                end
            end
            START: begin
                if (w_bit_end) w_state_nxt = DATA;
            end
            DATA: begin
                if (w_bit_end && (r_bit_cnt == r_len - LEN_W'(1))) begin
                    w_state_nxt = r_pen ? PARITY : STOP1;
                end
            end
            PARITY: begin
                if (w_bit_end) w_state_nxt = STOP1;
            end
            STOP1: begin
                if (w_bit_end) begin
                    if (r_stop2) begin
                        w_state_nxt = STOP2;
                    end else begin
                        w_state_nxt = IDLE;
                        w_try       = r_hold_full;
                    end
                end
            end
            STOP2, BRK_REC: begin
                if (w_bit_end) begin
                    w_state_nxt = IDLE;
                    w_try       = r_hold_full;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_try) begin
            if (w_len_ok) begin
                w_launch    = 1'b1;
                w_state_nxt = START;
                w_load      = 1'b1;
                w_load_div  = r_hold_cfg.div;
            end else begin
                w_drop = 1'b1;
            end
        end
    end

    always_ff @(posedge tx_clk or negedge rst) begin
        if (!rst) begin
            r_hold_full <= 1'b0;
            r_hold_data <= '0;
            r_hold_cfg  <= '0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_len       <= '0;
            r_pen       <= 1'b0;
            r_stop2     <= 1'b0;
            r_par       <= 1'b0;
            r_brk       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Launch/drop frees the buffer; an accept in the same cycle refills it.
            r_hold_full <= w_accept || (r_hold_full && !(w_launch || w_drop));
            if (w_accept) begin
                r_hold_data <= s_if.s_data;
                r_hold_cfg  <= '{div: divisor, len: length, pen: parity_en,
                                 ptype: parity_e'(parity_type), stop2: stop2};
            end
            if (w_launch) begin
                r_shift   <= r_hold_data;
                r_bit_cnt <= '0;
                r_len     <= r_hold_cfg.len;
                r_pen     <= r_hold_cfg.pen;
                r_stop2   <= r_hold_cfg.stop2;
                r_par     <= parity_bit(16'(r_hold_data), 8'(r_hold_cfg.len), r_hold_cfg.ptype);
            end else if (r_state == DATA && w_bit_end) begin
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= r_bit_cnt + LEN_W'(1);
            end
            // Break is only honoured while idle; registering it keeps tx high out of reset.
            r_brk <= (r_state == IDLE) && brk;
            r_err <= w_drop;
        end
    end

    always_comb begin
        tx = 1'b1;
        case (r_state)
            IDLE:    tx = !r_brk;
            START:   tx = 1'b0;
            DATA:    tx = r_shift[0];
            PARITY:  tx = r_par;
            default: tx = 1'b1;
        endcase
    end

    assign tx_busy = (r_state != IDLE) || r_brk;
    assign tx_done = w_final_stop && w_bit_end;
    assign tx_err  = r_err;
endmodule

// File: tb/tb_uart_tx_gen.sv
module tb_uart_tx_gen;
    logic        clk;
    logic        rst;
    logic [15:0] divisor;
    logic [3:0]  length;
    logic        parity_en;
    logic [1:0]  parity_type;
    logic        stop2;
    logic        brk;
    logic        tx, tx_busy, tx_done, tx_err;

    int checks = 0;
    int errors = 0;

    uart_tx_gen_if #(.DATA_W(8)) s_if ();

    uart_tx_gen #(.DATA_W(8), .DIV_W(16), .LEN_W(4)) dut (
        .tx_clk      (clk),
        .rst         (rst),
        .divisor     (divisor),
        .length      (length),
        .parity_en   (parity_en),
        .parity_type (parity_type),
        .stop2       (stop2),
        .brk         (brk),
        .s_if        (s_if),
        .tx          (tx),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer one word for exactly one edge; returns at the negedge after acceptance.
    task automatic push(input logic [7:0] d);
        @(negedge clk);
        s_if.s_valid = 1'b1;
        s_if.s_data  = d;
        @(negedge clk);
        s_if.s_valid = 1'b0;
    endtask

    // Checks one whole frame clock by clock, starting at the next negedge.
    task automatic expect_frame(input string tag, input logic [8:0] data, input int len,
                                input bit pen, input bit pbit, input bit s2, input int d);
        logic exp_bits [0:12];
        int   nb;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < len; i++) exp_bits[1 + i] = data[i];
        nb = 1 + len;
        if (pen) begin
            exp_bits[nb] = pbit;
            nb++;
        end
        exp_bits[nb] = 1'b1;
        nb++;
        if (s2) begin
            exp_bits[nb] = 1'b1;
            nb++;
        end
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < d; c++) begin
                @(negedge clk);
                chk({tag, " tx"}, 32'(tx), 32'(exp_bits[b]));
                chk({tag, " done"}, 32'(tx_done), 32'((b == nb - 1) && (c == d - 1)));
                chk({tag, " busy"}, 32'(tx_busy), 32'd1);
            end
        end
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        chk({tag, " idle tx"}, 32'(tx), 32'd1);
        chk({tag, " idle busy"}, 32'(tx_busy), 32'd0);
        chk({tag, " idle done"}, 32'(tx_done), 32'd0);
    endtask

    logic [7:0] words [0:2];
    logic       exp_stream [0:33];
    logic       rdy_prev;
    int         idx;
    int         pos;

    initial begin
        rst = 1'b0;
        divisor = 16'd4; length = 4'd8; parity_en = 1'b0; parity_type = 2'b00;
        stop2 = 1'b0; brk = 1'b0;
        s_if.s_valid = 1'b0; s_if.s_data = 8'h00;

        // Reset state
        #12;
        chk("rst tx", 32'(tx), 32'd1);
        chk("rst s_ready", 32'(s_if.s_ready), 32'd1);
        chk("rst busy", 32'(tx_busy), 32'd0);
        chk("rst done", 32'(tx_done), 32'd0);
        chk("rst err", 32'(tx_err), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        expect_idle("post rst");

        // 1: 8N1 D=4, 0xA5; config changed after accept must not affect the frame
        push(8'hA5);
        divisor = 16'd7; length = 4'd5;
        expect_frame("t1", 9'h0A5, 8, 1'b0, 1'b0, 1'b0, 4);
        expect_idle("t1");

        // 2: len 7, even parity, 2 stop, D=2, 0x53 -> parity 0, 22 clocks
        divisor = 16'd2; length = 4'd7; parity_en = 1'b1; parity_type = 2'b00; stop2 = 1'b1;
        push(8'h53);
        expect_frame("t2 even", 9'h053, 7, 1'b1, 1'b0, 1'b1, 2);
        expect_idle("t2");

        // 3: odd -> 1, mark -> 1, space -> 0
        parity_type = 2'b01;
        push(8'h53);
        expect_frame("t3 odd", 9'h053, 7, 1'b1, 1'b1, 1'b1, 2);
        parity_type = 2'b10;
        push(8'h53);
        expect_frame("t3 mark", 9'h053, 7, 1'b1, 1'b1, 1'b1, 2);
        parity_type = 2'b11;
        push(8'h53);
        expect_frame("t3 space", 9'h053, 7, 1'b1, 1'b0, 1'b1, 2);
        expect_idle("t3");

        // 4: three words with s_valid held, 8N1, D=1: contiguous frames
        divisor = 16'd1; length = 4'd8; parity_en = 1'b0; stop2 = 1'b0;
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        for (int i = 0; i < 34; i++) exp_stream[i] = 1'b1;
        for (int f = 0; f < 3; f++) begin
            pos = 1 + 10 * f;
            exp_stream[pos] = 1'b0;
            for (int b = 0; b < 8; b++) exp_stream[pos + 1 + b] = words[f][b];
        end
        @(negedge clk);
        s_if.s_valid = 1'b1;
        s_if.s_data  = words[0];
        rdy_prev = s_if.s_ready;
        idx = 0;
        for (int cyc = 0; cyc < 34; cyc++) begin
            @(negedge clk);
            if (s_if.s_valid && rdy_prev) begin
                chk("t4 ready drop", 32'(s_if.s_ready), 32'd0);
                idx++;
                if (idx < 3) s_if.s_data = words[idx];
                else         s_if.s_valid = 1'b0;
            end
            rdy_prev = s_if.s_ready;
            chk($sformatf("t4 tx c%0d", cyc), 32'(tx), 32'(exp_stream[cyc]));
            chk($sformatf("t4 done c%0d", cyc), 32'(tx_done),
                32'((cyc == 10) || (cyc == 20) || (cyc == 30)));
        end
        chk("t4 words accepted", 32'(idx), 32'd3);

        // 5: illegal lengths 4 and 9 rejected, then a normal frame
        length = 4'd4;
        push(8'h0F);
        @(negedge clk);
        chk("t5 len4 err", 32'(tx_err), 32'd1);
        chk("t5 len4 tx", 32'(tx), 32'd1);
        chk("t5 len4 busy", 32'(tx_busy), 32'd0);
        chk("t5 len4 done", 32'(tx_done), 32'd0);
        chk("t5 len4 ready", 32'(s_if.s_ready), 32'd1);
        @(negedge clk);
        chk("t5 len4 err pulse", 32'(tx_err), 32'd0);
        length = 4'd9;
        push(8'hFF);
        @(negedge clk);
        chk("t5 len9 err", 32'(tx_err), 32'd1);
        chk("t5 len9 tx", 32'(tx), 32'd1);
        chk("t5 len9 done", 32'(tx_done), 32'd0);
        chk("t5 len9 ready", 32'(s_if.s_ready), 32'd1);
        @(negedge clk);
        chk("t5 len9 err pulse", 32'(tx_err), 32'd0);
        chk("t5 len9 tx after", 32'(tx), 32'd1);
        length = 4'd8; divisor = 16'd2;
        push(8'h3C);
        expect_frame("t5 good", 9'h03C, 8, 1'b0, 1'b0, 1'b0, 2);
        expect_idle("t5");

        // 6a: break for 20 clocks with a word buffered, D=3
        divisor = 16'd3;
        @(negedge clk);
        brk = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                s_if.s_valid = 1'b1;
                s_if.s_data  = 8'h96;
            end
            if (i == 2) begin
                s_if.s_valid = 1'b0;
                chk("t6 buffered", 32'(s_if.s_ready), 32'd0);
            end
            chk($sformatf("t6 brk tx %0d", i), 32'(tx), 32'd0);
            chk($sformatf("t6 brk busy %0d", i), 32'(tx_busy), 32'd1);
            if (i == 20) brk = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("t6 recover tx %0d", i), 32'(tx), 32'd1);
            chk($sformatf("t6 recover busy %0d", i), 32'(tx_busy), 32'd1);
        end
        expect_frame("t6 after brk", 9'h096, 8, 1'b0, 1'b0, 1'b0, 3);
        expect_idle("t6");

        // 6b: async reset during DATA (data 0x00 so the line is low there)
        divisor = 16'd4;
        push(8'h00);
        push(8'h55);
        repeat (6) @(negedge clk);
        chk("t6 pre-rst tx", 32'(tx), 32'd0);
        chk("t6 pre-rst ready", 32'(s_if.s_ready), 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("t6 async tx", 32'(tx), 32'd1);
        chk("t6 async ready", 32'(s_if.s_ready), 32'd1);
        chk("t6 async busy", 32'(tx_busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk($sformatf("t6 post-rst tx %0d", i), 32'(tx), 32'd1);
            chk($sformatf("t6 post-rst done %0d", i), 32'(tx_done), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
